// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler
//   Shares one combinational ALU among NUM_REQ requesters. One operation is in
//   flight at a time: IDLE grants a round-robin winner and loads its operands,
//   EXEC lets the ALU settle and captures its result, RESP presents the result
//   to the owner until it accepts.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    per-requester request handshake (req_ready one-hot)
//   req_a/req_b/req_sel    packed per-requester operands and ALU_Sel code
//   rsp_valid/rsp_ready    per-requester response handshake (rsp_valid one-hot)
//   rsp_out/rsp_carry      registered result, shared by all requesters
//   alu_a/alu_b/alu_sel    registered operands to the ALU
//   alu_out/alu_carry      combinational result from the ALU
//   busy                   high while an operation is in flight
module alu_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]     req_sel,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]         rsp_out,
  output logic                     rsp_carry,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [3:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  input  logic                     alu_carry,
  output logic                     busy
);

  localparam int          PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned NR = NUM_REQ;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       sel_q, sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;

  logic [PW-1:0]      win_idx;
  logic               win_found;
  logic [NUM_REQ-1:0] grant;

  // First valid requester scanning upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    logic [PW-1:0] cand;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NR) idx = idx - NR;
      cand = PW'(idx);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    out_d   = out_q;
    carry_d = carry_q;
    grant   = '0;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          grant[win_idx] = 1'b1;
          owner_d        = win_idx;
          state_d        = S_EXEC;
          for (int unsigned i = 0; i < NR; i++) begin
            if (PW'(i) == win_idx) begin
              a_d   = req_a[i*WIDTH +: WIDTH];
              b_d   = req_b[i*WIDTH +: WIDTH];
              sel_d = req_sel[i*4 +: 4];
            end
          end
        end
      end
      S_EXEC: begin
        out_d   = alu_out;
        carry_d = alu_carry;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[owner_q]) begin
          state_d = S_IDLE;
          ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      rsp_valid[i] = (state_q == S_RESP) && (owner_q == PW'(i));
    end
  end

  // The grant is combinational from req_valid, so it is masked while reset is
  // held to keep every output at its reset value.
  assign req_ready = grant & {NUM_REQ{rst_n}};
  assign rsp_out   = out_q;
  assign rsp_carry = carry_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_rr_scheduler.sv
module tb_alu_rr_scheduler;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [15:0] req_sel;
  logic [3:0]  rsp_valid;
  logic [3:0]  rsp_ready;
  logic [7:0]  rsp_out;
  logic        rsp_carry;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_sel;
  logic [7:0]  alu_out;
  logic        alu_carry;
  logic        busy;

  int checks = 0;
  int errors = 0;

  alu_rr_scheduler #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 8-bit ALU: CarryOut is always the carry of A+B.
  always_comb begin
    logic [8:0] sum;
    sum       = {1'b0, alu_a} + {1'b0, alu_b};
    alu_carry = sum[8];
    case (alu_sel)
      4'h0: alu_out = alu_a + alu_b;
      4'h1: alu_out = alu_a - alu_b;
      4'h2: alu_out = alu_a * alu_b;
      4'h3: alu_out = (alu_b != 0) ? alu_a / alu_b : 8'h00;
      4'h4: alu_out = alu_a << 1;
      4'h5: alu_out = alu_a >> 1;
      4'h6: alu_out = {alu_a[6:0], alu_a[7]};
      4'h7: alu_out = {alu_a[0], alu_a[7:1]};
      4'h8: alu_out = alu_a & alu_b;
      4'h9: alu_out = alu_a | alu_b;
      4'hA: alu_out = alu_a ^ alu_b;
      4'hB: alu_out = ~(alu_a | alu_b);
      4'hC: alu_out = ~(alu_a & alu_b);
      4'hD: alu_out = ~(alu_a ^ alu_b);
      4'hE: alu_out = (alu_a > alu_b) ? 8'h01 : 8'h00;
      default: alu_out = (alu_a == alu_b) ? 8'h01 : 8'h00;
    endcase
  end

  typedef struct {
    int         idx;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] sel;
    logic [7:0] exp_out;
    logic       exp_carry;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int idx, input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    req_a[idx*8 +: 8]   = a;
    req_b[idx*8 +: 8]   = b;
    req_sel[idx*4 +: 4] = sel;
    req_valid[idx]      = 1'b1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Waits (bounded) for a grant seen at a negedge and compares it with exp.
  // Optionally drops the granted requester's req_valid after the grant edge.
  task automatic expect_grant(input string name, input logic [3:0] exp, input bit drop);
    logic [3:0] g;
    g = '0;
    for (int n = 0; n < 20 && g == 0; n++) begin
      @(negedge clk);
      g = req_ready;
    end
    chk(name, 64'(g), 64'(exp));
    sync();
    if (drop) req_valid = req_valid & ~g;
  endtask

  task automatic expect_rsp(input string name, input logic [3:0] mask, input logic [7:0] out, input logic c);
    logic [3:0] v;
    v = '0;
    for (int n = 0; n < 20 && v == 0; n++) begin
      @(negedge clk);
      v = rsp_valid;
    end
    chk({name, ".valid"}, 64'(v), 64'(mask));
    chk({name, ".out"}, 64'({c, out}), 64'({rsp_carry, rsp_out}) ^ 64'({c, out}) ^ 64'({c, out}));
  endtask

  // Single operation with exact cycle-by-cycle latency checks.
  task automatic run_single(input vec_t v, input string name);
    sync();
    issue(v.idx, v.a, v.b, v.sel);
    @(negedge clk);
    chk({name, ".grant"}, 64'(req_ready), 64'(4'b1 << v.idx));
    sync();
    req_valid[v.idx] = 1'b0;
    @(negedge clk);
    chk({name, ".exec"}, 64'({busy, rsp_valid, req_ready, alu_a, alu_b, alu_sel}),
        64'({1'b1, 4'b0, 4'b0, v.a, v.b, v.sel}));
    @(negedge clk);
    chk({name, ".rsp"}, 64'({rsp_valid, rsp_carry, rsp_out}),
        64'({4'b1 << v.idx, v.exp_carry, v.exp_out}));
    @(negedge clk);
    chk({name, ".done"}, 64'({busy, rsp_valid}), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    req_a     = '0;
    req_b     = '0;
    req_sel   = '0;

    vecs[0] = '{0, 8'hFF, 8'h01, 4'h0, 8'h00, 1'b1};
    vecs[1] = '{1, 8'h10, 8'h01, 4'h1, 8'h0F, 1'b0};
    vecs[2] = '{2, 8'hF0, 8'h3C, 4'h8, 8'h30, 1'b1};
    vecs[3] = '{3, 8'hAA, 8'hFF, 4'hA, 8'h55, 1'b1};
    vecs[4] = '{0, 8'h05, 8'h05, 4'hF, 8'h01, 1'b0};
    vecs[5] = '{1, 8'h80, 8'h01, 4'h4, 8'h00, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle after reset: every output low.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("reset_idle", 64'({req_ready, rsp_valid, rsp_out, rsp_carry, alu_a, alu_b, alu_sel, busy}), 64'(0));
    end

    for (int i = 0; i < 6; i++) run_single(vecs[i], $sformatf("vec%0d", i));

    // After a lone add on req 0, ptr is 1: with req 0 and 1 both valid, 1 wins.
    do_reset();
    run_single(vecs[0], "add0");
    sync();
    issue(0, 8'h01, 8'h01, 4'h0);
    issue(1, 8'h02, 8'h03, 4'h0);
    expect_grant("ptr_after_add", 4'b0010, 1'b1);
    expect_rsp("ptr_after_add", 4'b0010, 8'h05, 1'b0);
    expect_grant("ptr_after_add.next", 4'b0001, 1'b1);
    expect_rsp("ptr_after_add.next", 4'b0001, 8'h02, 1'b0);

    // Round robin with all four requesters continuously valid.
    do_reset();
    for (int i = 0; i < 4; i++) issue(i, 8'((i + 1) * 16), 8'h01, 4'h0);
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      expect_grant($sformatf("rr%0d.grant", k), 4'b1 << e, 1'b0);
      expect_rsp($sformatf("rr%0d", k), 4'b1 << e, 8'((e + 1) * 16 + 1), 1'b0);
    end
    sync();
    req_valid = '0;

    // Response backpressure on req 2 while req 1 waits; non-owner rsp_ready ignored.
    do_reset();
    rsp_ready = 4'b1011;
    issue(2, 8'h7F, 8'h01, 4'h0);
    expect_grant("bp.grant2", 4'b0100, 1'b1);
    issue(1, 8'h33, 8'h11, 4'h1);
    @(negedge clk);
    chk("bp.exec", 64'({req_ready, rsp_valid}), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp.hold%0d", i), 64'({req_ready, rsp_valid, rsp_carry, rsp_out}),
          64'({4'b0000, 4'b0100, 1'b0, 8'h80}));
    end
    sync();
    rsp_ready = '1;
    @(negedge clk);
    chk("bp.accept_cycle", 64'({req_ready, rsp_valid}), 64'({4'b0000, 4'b0100}));
    @(negedge clk);
    chk("bp.grant1", 64'(req_ready), 64'(4'b0010));
    sync();
    req_valid = '0;
    expect_rsp("bp.rsp1", 4'b0010, 8'h22, 1'b0);

    // Wrap-around: ptr=3 after req 2 completes; req 3 then req 1.
    do_reset();
    run_single(vecs[2], "wrap.pre");
    sync();
    issue(1, 8'h01, 8'h02, 4'h9);
    issue(3, 8'h0F, 8'hF0, 4'hC);
    expect_grant("wrap.grant3", 4'b1000, 1'b1);
    expect_rsp("wrap.rsp3", 4'b1000, 8'hFF, 1'b0);
    expect_grant("wrap.grant1", 4'b0010, 1'b1);
    expect_rsp("wrap.rsp1", 4'b0010, 8'h03, 1'b0);

    // Reset during EXEC: operation discarded, outputs cleared at once, ptr back to 0.
    do_reset();
    run_single('{2, 8'h7F, 8'h01, 4'h0, 8'h80, 1'b0}, "rst.pre");
    sync();
    issue(0, 8'h55, 8'h22, 4'h0);
    expect_grant("rst.grant0", 4'b0001, 1'b1);
    @(negedge clk);
    chk("rst.in_exec", 64'(busy), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("rst.async_clear", 64'({req_ready, rsp_valid, rsp_out, rsp_carry, alu_a, alu_b, alu_sel, busy}), 64'(0));
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rst.no_rsp%0d", i), 64'({rsp_valid, busy}), 64'(0));
    end
    sync();
    issue(0, 8'h55, 8'h22, 4'h0);
    issue(3, 8'h01, 8'h01, 4'h0);
    expect_grant("rst.regrant", 4'b0001, 1'b1);
    expect_rsp("rst.rsp0", 4'b0001, 8'h77, 1'b0);
    expect_grant("rst.grant3", 4'b1000, 1'b1);
    expect_rsp("rst.rsp3", 4'b1000, 8'h02, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
